// File: rtl/stack_pkg.sv
// Shared command and error encodings for the operand stack and the
// instruction decoder that drives its cmd port.
package stack_pkg;

    localparam logic [2:0] CMD_NOP   = 3'b000;
    localparam logic [2:0] CMD_PUSH  = 3'b001;
    localparam logic [2:0] CMD_POP   = 3'b010;
    localparam logic [2:0] CMD_BINOP = 3'b011;
    localparam logic [2:0] CMD_UNOP  = 3'b100;
    localparam logic [2:0] CMD_DUP   = 3'b101;
    localparam logic [2:0] CMD_SWAP  = 3'b110;
    localparam logic [2:0] CMD_CLEAR = 3'b111;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_OVF  = 2'b01;
    localparam logic [1:0] ERR_UNF  = 2'b10;

endpackage

// File: rtl/operand_stack.sv
// Operand stack feeding the ALU: presents the top two entries, writes ALU
// results back and retires one command per clock with a sticky error flag.
module operand_stack
    import stack_pkg::*;
#(
    parameter int REG_BITS = 32,
    parameter int DEPTH    = 16,
    parameter int PTR_BITS = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [2:0]          cmd,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [REG_BITS-1:0] push_data,
    input  logic [REG_BITS-1:0] alu_result,
    output logic [REG_BITS-1:0] operand1,
    output logic [REG_BITS-1:0] operand2,
    output logic [PTR_BITS-1:0] depth,
    output logic                empty,
    output logic                full,
    output logic                err,
    output logic [1:0]          err_code,
    input  logic                err_clr
);

    // Handshake: a command is taken on a rising edge when cmd_valid && cmd_ready;
    // cmd_ready drops while the sticky error is set, so err_clr always wins.

    localparam int IDX_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_BITS-1:0] SP_FULL = PTR_BITS'(DEPTH);
    localparam logic [PTR_BITS-1:0] SP_ONE  = PTR_BITS'(1);
    localparam logic [PTR_BITS-1:0] SP_TWO  = PTR_BITS'(2);

    logic [REG_BITS-1:0] mem [DEPTH];
    logic [PTR_BITS-1:0] sp;

    logic                accept;
    logic                legal;
    logic [1:0]          fault;
    logic [IDX_BITS-1:0] push_idx;
    logic [IDX_BITS-1:0] top_idx;
    logic [IDX_BITS-1:0] nos_idx;

    // Indices may alias out-of-range slots; every use is guarded by sp.
    assign push_idx = IDX_BITS'(sp);
    assign top_idx  = IDX_BITS'(sp - SP_ONE);
    assign nos_idx  = IDX_BITS'(sp - SP_TWO);

    assign cmd_ready = !err;
    assign accept    = cmd_valid && cmd_ready;
    assign depth     = sp;
    assign empty     = (sp == '0);
    assign full      = (sp == SP_FULL);
    assign operand2  = (sp >= SP_ONE) ? mem[top_idx] : '0;
    assign operand1  = (sp >= SP_TWO) ? mem[nos_idx] : '0;

    always_comb begin
        legal = 1'b1;
        fault = ERR_NONE;
        case (cmd)
            CMD_PUSH: begin
                if (full) begin
                    legal = 1'b0;
                    fault = ERR_OVF;
                end
            end
            CMD_POP, CMD_UNOP: begin
                if (sp < SP_ONE) begin
                    legal = 1'b0;
                    fault = ERR_UNF;
                end
            end
            CMD_BINOP, CMD_SWAP: begin
                if (sp < SP_TWO) begin
                    legal = 1'b0;
                    fault = ERR_UNF;
                end
            end
            CMD_DUP: begin
                // Empty takes precedence: there is nothing to duplicate.
                if (empty) begin
                    legal = 1'b0;
                    fault = ERR_UNF;
                end else if (full) begin
                    legal = 1'b0;
                    fault = ERR_OVF;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp       <= '0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (accept) begin
            if (!legal) begin
                err      <= 1'b1;
                err_code <= fault;
            end else begin
                case (cmd)
                    CMD_PUSH: begin
                        mem[push_idx] <= push_data;
                        sp            <= sp + SP_ONE;
                    end
                    CMD_POP: sp <= sp - SP_ONE;
                    CMD_BINOP: begin
                        mem[nos_idx] <= alu_result;
                        sp           <= sp - SP_ONE;
                    end
                    CMD_UNOP: mem[top_idx] <= alu_result;
                    CMD_DUP: begin
                        mem[push_idx] <= mem[top_idx];
                        sp            <= sp + SP_ONE;
                    end
                    CMD_SWAP: begin
                        mem[top_idx] <= mem[nos_idx];
                        mem[nos_idx] <= mem[top_idx];
                    end
                    CMD_CLEAR: sp <= '0;
                    default: ;
                endcase
            end
        end else if (err && err_clr) begin
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end
    end

endmodule

// File: tb/tb_operand_stack.sv
// Directed bench for operand_stack: a queue-based stack model checked every
// cycle, plus hand-computed expectations from the test plan.
module tb_operand_stack;
    import stack_pkg::*;

    localparam int W     = 32;
    localparam int DEPTH = 16;
    localparam int PB    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [2:0]    cmd = CMD_NOP;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [W-1:0]  push_data = '0;
    logic [W-1:0]  alu_result = '0;
    logic [W-1:0]  operand1;
    logic [W-1:0]  operand2;
    logic [PB-1:0] depth;
    logic          empty;
    logic          full;
    logic          err;
    logic [1:0]    err_code;
    logic          err_clr = 1'b0;

    operand_stack #(.REG_BITS(W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .push_data(push_data), .alu_result(alu_result),
        .operand1(operand1), .operand2(operand2), .depth(depth),
        .empty(empty), .full(full), .err(err), .err_code(err_code),
        .err_clr(err_clr)
    );

    // clock / reset
    always #5 clk = ~clk;

    // model state
    logic [W-1:0] exp_q[$];
    logic         exp_err = 1'b0;
    logic [1:0]   exp_code = 2'b00;
    logic         cmp_en = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_err  = 1'b0;
        exp_code = 2'b00;
    endtask

    task automatic model_flag(input logic [1:0] code);
        exp_err  = 1'b1;
        exp_code = code;
    endtask

    task automatic model_apply(input logic [2:0] c, input logic v, input logic [W-1:0] pd,
                               input logic [W-1:0] ar, input logic clr);
        int n;
        logic [W-1:0] t;
        n = exp_q.size();
        if (exp_err) begin
            if (clr) begin
                exp_err  = 1'b0;
                exp_code = 2'b00;
            end
        end else if (v) begin
            case (c)
                CMD_PUSH:  if (n == DEPTH) model_flag(2'b01); else exp_q.push_back(pd);
                CMD_POP:   if (n < 1) model_flag(2'b10); else void'(exp_q.pop_back());
                CMD_BINOP: begin
                    if (n < 2) model_flag(2'b10);
                    else begin
                        void'(exp_q.pop_back());
                        exp_q[n-2] = ar;
                    end
                end
                CMD_UNOP:  if (n < 1) model_flag(2'b10); else exp_q[n-1] = ar;
                CMD_DUP: begin
                    if (n == 0) model_flag(2'b10);
                    else if (n == DEPTH) model_flag(2'b01);
                    else exp_q.push_back(exp_q[n-1]);
                end
                CMD_SWAP: begin
                    if (n < 2) model_flag(2'b10);
                    else begin
                        t = exp_q[n-1];
                        exp_q[n-1] = exp_q[n-2];
                        exp_q[n-2] = t;
                    end
                end
                CMD_CLEAR: exp_q.delete();
                default: ;
            endcase
        end
    endtask

    // driver: called just after a rising edge, returns 1 time unit after the next
    task automatic step(input logic [2:0] c, input logic v, input logic [W-1:0] pd,
                        input logic [W-1:0] ar, input logic clr);
        cmd        = c;
        cmd_valid  = v;
        push_data  = pd;
        alu_result = ar;
        err_clr    = clr;
        @(posedge clk);
        model_apply(c, v, pd, ar, clr);
        #1;
        cmd_valid = 1'b0;
        err_clr   = 1'b0;
        cmd       = CMD_NOP;
    endtask

    task automatic op(input logic [2:0] c, input logic [W-1:0] d);
        step(c, 1'b1, d, d, 1'b0);
    endtask

    task automatic clear_err();
        step(CMD_NOP, 1'b0, '0, '0, 1'b1);
    endtask

    // scoreboard compare on the falling edge
    always @(negedge clk) begin
        if (cmp_en) begin
            int n;
            n = exp_q.size();
            check("depth",     W'(depth),     W'(n));
            check("empty",     W'(empty),     W'(n == 0));
            check("full",      W'(full),      W'(n == DEPTH));
            check("operand2",  operand2,      (n >= 1) ? exp_q[n-1] : '0);
            check("operand1",  operand1,      (n >= 2) ? exp_q[n-2] : '0);
            check("err",       W'(err),       W'(exp_err));
            check("err_code",  W'(err_code),  W'(exp_code));
            check("cmd_ready", W'(cmd_ready), W'(!exp_err));
        end
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        cmp_en = 1'b1;
        check("rst_depth", W'(depth), 0);
        check("rst_empty", W'(empty), 1);
        check("rst_ready", W'(cmd_ready), 1);
        check("rst_op2",   operand2, 0);

        // push / binop sub: 7 - 5 = 2
        op(CMD_PUSH, 7);
        op(CMD_PUSH, 5);
        check("tp1_depth", W'(depth), 2);
        check("tp1_op1", operand1, 7);
        check("tp1_op2", operand2, 5);
        op(CMD_BINOP, 2);
        check("tp1_bin_depth", W'(depth), 1);
        check("tp1_bin_op2", operand2, 2);
        check("tp1_bin_op1", operand1, 0);

        // unop
        op(CMD_CLEAR, 0);
        op(CMD_PUSH, 32'h0000_000F);
        op(CMD_UNOP, 32'hFFFF_FFF0);
        check("unop_depth", W'(depth), 1);
        check("unop_op2", operand2, 32'hFFFF_FFF0);

        // fill, overflow, ignored pop, clear, pop
        op(CMD_CLEAR, 0);
        for (int i = 0; i < DEPTH; i++) op(CMD_PUSH, W'(32'h100 + i));
        check("fill_full", W'(full), 1);
        check("fill_op2", operand2, 32'h10F);
        op(CMD_PUSH, 32'h99);
        check("ovf_err", W'(err), 1);
        check("ovf_code", W'(err_code), 1);
        check("ovf_ready", W'(cmd_ready), 0);
        check("ovf_depth", W'(depth), 16);
        op(CMD_POP, 0);
        check("ign_depth", W'(depth), 16);
        clear_err();
        check("clr_err", W'(err), 0);
        op(CMD_POP, 0);
        check("pop_depth", W'(depth), 15);

        // underflows
        op(CMD_CLEAR, 0);
        op(CMD_POP, 0);
        check("unf_pop_code", W'(err_code), 2);
        check("unf_pop_depth", W'(depth), 0);
        clear_err();
        op(CMD_DUP, 0);
        check("unf_dup_code", W'(err_code), 2);
        clear_err();
        op(CMD_PUSH, 32'h42);
        op(CMD_BINOP, 32'hDEAD);
        check("unf_bin_code", W'(err_code), 2);
        check("unf_bin_op2", operand2, 32'h42);
        check("unf_bin_depth", W'(depth), 1);
        clear_err();

        // swap / dup / clear
        op(CMD_CLEAR, 0);
        op(CMD_PUSH, 3);
        op(CMD_PUSH, 9);
        op(CMD_SWAP, 0);
        check("swap_op1", operand1, 9);
        check("swap_op2", operand2, 3);
        op(CMD_DUP, 0);
        check("dup_depth", W'(depth), 3);
        check("dup_op1", operand1, 3);
        check("dup_op2", operand2, 3);
        op(CMD_CLEAR, 0);
        check("clear_depth", W'(depth), 0);
        check("clear_empty", W'(empty), 1);

        // err_clr with no error does not block a command
        step(CMD_PUSH, 1'b1, 32'h55, 0, 1'b1);
        check("clr_noerr_depth", W'(depth), 1);
        check("clr_noerr_op2", operand2, 32'h55);

        // dup to full then dup overflow; err_clr beats a same-cycle push
        for (int i = 0; i < DEPTH - 1; i++) op(CMD_DUP, 0);
        check("dup_full", W'(full), 1);
        op(CMD_DUP, 0);
        check("dup_ovf_code", W'(err_code), 1);
        step(CMD_POP, 1'b1, 0, 0, 1'b1);
        check("clr_prio_err", W'(err), 0);
        check("clr_prio_depth", W'(depth), 16);

        // async reset between edges while in error
        op(CMD_PUSH, 32'h77);
        check("pre_rst_err", W'(err), 1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_depth", W'(depth), 0);
        check("arst_err", W'(err), 0);
        check("arst_ready", W'(cmd_ready), 1);
        check("arst_op1", operand1, 0);
        check("arst_op2", operand2, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        op(CMD_POP, 0);
        check("post_rst_pop_code", W'(err_code), 2);
        clear_err();
        op(CMD_PUSH, 32'hA5A5_0001);
        check("post_rst_push_op2", operand2, 32'hA5A5_0001);

        repeat (2) @(posedge clk);
        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/operand_stack.md
Name: operand_stack

Overview:
- Hardware operand stack that feeds the ALU and takes its results back.
- Presents the top two entries as the ALU's operand1 (next-of-top) and operand2 (top).
- Accepts ALUResult for writeback, so one command per cycle retires a stack-machine instruction.
- Also handles push-immediate, pop, dup, swap and clear, with overflow/underflow detection and a sticky error handshake.

Parameters:
- REG_BITS, 32, data width of each entry and of the ALU operand/result buses.
- DEPTH, 16, number of entries (≥2).
- PTR_BITS, $clog2(DEPTH+1), width of the depth counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- cmd  in  3  stack command (codes under Behaviour).
- cmd_valid  in  1  command present this cycle.
- cmd_ready  out  1  stack accepts the command; equals !err.
- push_data  in  REG_BITS  value for PUSH.
- alu_result  in  REG_BITS  ALUResult, written back by BINOP/UNOP.
- operand1  out  REG_BITS  entry at depth-2; 0 if depth<2.
- operand2  out  REG_BITS  entry at depth-1 (top); 0 if depth<1.
- depth  out  PTR_BITS  current entry count.
- empty  out  1  depth==0.
- full  out  1  depth==DEPTH.
- err  out  1  sticky error flag.
- err_code  out  2  01 overflow, 10 underflow, 00 none.
- err_clr  in  1  clears err/err_code.

Behaviour:
- Storage: mem[0..DEPTH-1], sp = depth. Entry i is valid for i<sp; top is mem[sp-1].
- Reset (async, rst_n=0): sp=0, all mem=0, err=0, err_code=00. Resulting outputs: cmd_ready=1, empty=1, full=0, operand1=operand2=0.
- Outputs operand1, operand2, depth, empty and full are combinational from registered state. The ALU result for the current cmd is produced in the same cycle, so every command completes in one clock with zero added latency.
- Accept = cmd_valid && cmd_ready. On a cycle without accept there is no state change.
- Command codes (in package):
  - 000 NOP: no change.
  - 001 PUSH: needs sp<DEPTH; mem[sp]<=push_data; sp+1.
  - 010 POP: needs sp≥1; sp-1. The discarded entry is not cleared.
  - 011 BINOP: needs sp≥2; mem[sp-2]<=alu_result; sp-1. This is the pop-two / push-one form, so sub computes next-of-top minus top.
  - 100 UNOP: needs sp≥1; mem[sp-1]<=alu_result; sp unchanged (neg/not).
  - 101 DUP: needs 1≤sp<DEPTH; mem[sp]<=mem[sp-1]; sp+1.
  - 110 SWAP: needs sp≥2; exchange mem[sp-1] and mem[sp-2].
  - 111 CLEAR: sp<=0; always legal.
- Illegal accepted command:
  - No change to mem or sp.
  - err<=1 on the next edge.
  - err_code<=01 for PUSH/DUP when full; 10 for POP/BINOP/UNOP/SWAP below the required depth.
  - DUP with sp=0 reports underflow (10).
- While err=1: cmd_ready=0 and commands are ignored; the stack contents stay intact for debug.
- err_clr=1 clears err and err_code on the next edge. It has priority over any cmd in the same cycle; the cmd is not accepted.
- err_clr while err=0 has no effect and does not block a command.
- Boundary conditions:
  - sp saturates within 0..DEPTH.
  - PUSH at sp=DEPTH-1 reaches full=1.
  - POP at sp=1 reaches empty=1.
  - No wrap-around of sp in either direction.
- Reset asserted mid-stream overrides everything immediately. The first command after rst_n deasserts is evaluated against sp=0.

Decomposition:
- Shared package stack_pkg:
  - cmd codes CMD_NOP…CMD_CLEAR as 3-bit localparams.
  - ERR_NONE/ERR_OVF/ERR_UNF as 2-bit constants.
- The same package is used by the decoder that drives cmd, ALUOp, ALUSrc and opcode2.
- No sub-module is needed. The register file and the sp/err control sit in one module; a separate RAM macro is not warranted at DEPTH=16.

Test Plan:
- Reset, then PUSH 7, PUSH 5 -> depth=2, operand1=7, operand2=5. Drive alu_result=2 (sub) with BINOP -> depth=1, operand2=2, operand1=0.
- PUSH 0x0000000F, then UNOP with alu_result=0xFFFFFFF0 -> depth unchanged, operand2=0xFFFFFFF0.
- With DEPTH=16, 16 PUSHes -> full=1. 17th PUSH -> err=1, err_code=01, cmd_ready=0, depth=16. Next POP is ignored. err_clr -> err=0, then POP -> depth=15.
- From empty, POP -> err_code=10, depth=0. From depth=1, BINOP -> err_code=10, top entry preserved.
- PUSH 3, PUSH 9, SWAP -> operand1=9, operand2=3. DUP -> depth=3, operand1=3, operand2=3. CLEAR -> depth=0, empty=1.
- Assert rst_n=0 asynchronously between edges at depth=5 with err=1 -> outputs reset without waiting for clk. Same cycle as err_clr plus a valid PUSH -> PUSH not accepted.
